// File: rtl/leiwand_rv32_wb_interconnect.sv
// leiwand_rv32_wb_interconnect
// Single-master, N-slave classic Wishbone interconnect with one outstanding
// transfer. Slaves are selected by base/size address windows, the selected
// slave is registered at acceptance, read data is muxed from that slave only,
// and unmapped addresses or silent slaves terminate the cycle with wb_err.
//
// Handshake summary: a request is wb_cyc && wb_stb. In IDLE it is forwarded
// as s_stb to the decoded slave and wb_stall mirrors that slave's s_stall; the
// transfer is accepted in the cycle where the request is present and the
// slave does not stall. Afterwards the interconnect stalls the master until
// the selected slave acks (wb_ack, same cycle), the timeout expires or the
// master drops wb_cyc (wb_err in a single ERR cycle, or silent abort).
module leiwand_rv32_wb_interconnect #(
    parameter int MEM_WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE = {32'h20000000, 32'h10000000},
    parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZE = {32'h00001000, 32'h00001000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wb_cyc,
    input  logic                            wb_stb,
    input  logic                            wb_we,
    input  logic [MEM_WIDTH-1:0]            wb_addr,
    input  logic [MEM_WIDTH-1:0]            wb_data_out,
    output logic [MEM_WIDTH-1:0]            wb_data_in,
    output logic                            wb_ack,
    output logic                            wb_err,
    output logic                            wb_stall,
    output logic [NUM_SLAVES-1:0]           s_stb,
    output logic [NUM_SLAVES-1:0]           s_cyc,
    output logic                            s_we,
    output logic [MEM_WIDTH-1:0]            s_addr,
    output logic [MEM_WIDTH-1:0]            s_data_out,
    input  logic [NUM_SLAVES*MEM_WIDTH-1:0] s_data_in,
    input  logic [NUM_SLAVES-1:0]           s_ack,
    input  logic [NUM_SLAVES-1:0]           s_stall,
    output logic [7:0]                      err_count,
    output logic [MEM_WIDTH-1:0]            err_addr,
    output logic [1:0]                      dbg_state
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [7:0]           err_count_q, err_count_d;

    logic                 hit_any;
    logic [SEL_W-1:0]     hit_idx;
    logic [MEM_WIDTH:0]   addr_x;
    logic [MEM_WIDTH:0]   base_x;
    logic [MEM_WIDTH:0]   size_x;
    logic                 req;

    // Broadcast signals go to every slave unchanged.
    assign s_we       = wb_we;
    assign s_addr     = wb_addr;
    assign s_data_out = wb_data_out;

    assign err_count  = err_count_q;
    assign err_addr   = err_addr_q;
    assign dbg_state  = state_q;

    assign req = wb_cyc && wb_stb;

    // Address decode, one extra bit so windows ending at 2^MEM_WIDTH do not
    // wrap; scanning downwards lets the lowest matching slave win.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        addr_x  = {1'b0, wb_addr};
        base_x  = '0;
        size_x  = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            base_x = {1'b0, SLAVE_BASE[k*MEM_WIDTH +: MEM_WIDTH]};
            size_x = {1'b0, SLAVE_SIZE[k*MEM_WIDTH +: MEM_WIDTH]};
            if ((addr_x >= base_x) && ((addr_x - base_x) < size_x)) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    // Next-state and output logic; reset forces the master-facing outputs
    // to their idle values without waiting for a clock edge.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        wb_ack      = 1'b0;
        wb_err      = 1'b0;
        wb_stall    = 1'b1;
        wb_data_in  = '0;
        s_stb       = '0;
        s_cyc       = '0;

        case (state_q)
            IDLE: begin
                wb_stall = 1'b0;
                if (hit_any) begin
                    s_cyc[hit_idx] = wb_cyc;
                end
                if (req) begin
                    if (hit_any) begin
                        s_stb[hit_idx] = 1'b1;
                        wb_stall       = s_stall[hit_idx];
                        if (!s_stall[hit_idx]) begin
                            sel_d   = hit_idx;
                            cnt_d   = '0;
                            addr_d  = wb_addr;
                            state_d = WAIT_ACK;
                        end
                    end else begin
                        err_addr_d = wb_addr;
                        state_d    = ERR;
                    end
                end
            end

            WAIT_ACK: begin
                s_cyc[sel_q] = wb_cyc;
                if (!wb_cyc) begin
                    // Master abandoned the cycle: nothing is forwarded.
                    state_d = IDLE;
                end else if (s_ack[sel_q]) begin
                    wb_ack     = 1'b1;
                    wb_data_in = s_data_in[sel_q*MEM_WIDTH +: MEM_WIDTH];
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_addr_d = addr_q;
                    state_d    = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ERR: begin
                wb_err = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (!reset) begin
            wb_ack     = 1'b0;
            wb_err     = 1'b0;
            wb_stall   = 1'b1;
            wb_data_in = '0;
            s_stb      = '0;
            s_cyc      = '0;
        end
    end

    // State, selection, timeout and error bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

endmodule
